// File: rtl/uart_rx_param_if.sv
// Word-side interface of the parametrised UART receiver.
// master: receiver side (drives rx_data/rx_valid/flags, samples rx_ready).
// slave : consumer side (samples word and flags, drives rx_ready).
//   rx_data    DATA_W  received word, stable while rx_valid=1
//   rx_valid   1       word available
//   rx_ready   1       consumer accepts word when rx_valid & rx_ready
//   frame_err  1       stop-bit error for the presented word
//   parity_err 1       parity error for the presented word
//   break_det  1       break flag for the presented word
interface uart_rx_param_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_err;
  logic              parity_err;
  logic              break_det;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, break_det,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, break_det,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchronised rxd, mid-bit sampling with
// false-start rejection, configurable data width / parity / stop bits, and a
// single-word holding register with valid/ready handshake and overrun pulse.
// Optional feature: define UART_RX_BREAK_EN to flag all-zero frames on break_det.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   en       receiver enable, gates new frame starts only
//   rxd      asynchronous serial input, idle high
//   rx_if    word interface (master modport)
//   overrun  one-cycle pulse, completed frame dropped (holding register full)
//   busy     high whenever the frame FSM is outside IDLE
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 12,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            rxd,
  uart_rx_param_if.master rx_if,
  output logic            overrun,
  output logic            busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam logic        PAR_ODD = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [1:0]        r_sync;
  logic              w_rs;
  state_t            r_state,  w_state_nx;
  logic              r_armed,  w_armed_nx;
  logic [CNT_W-1:0]  r_cnt,    w_cnt_nx;
  logic [BIT_W-1:0]  r_bit,    w_bit_nx;
  logic              r_stop,   w_stop_nx;
  logic [DATA_W-1:0] r_shift,  w_shift_nx;
  logic              r_par,    w_par_nx;
  logic              r_ferr,   w_ferr_nx;
  logic              r_zero,   w_zero_nx;
  logic              w_done;
  logic              w_perr;
  logic              w_brk;

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_frame_err;
  logic              r_parity_err;
  logic              r_break_det;

  assign w_rs = r_sync[1];

  // Parity check on the completed frame; odd parity expects a total XOR of 1.
  assign w_perr = (PARITY != 0) && (((^r_shift) ^ r_par) != PAR_ODD);

  // Frame FSM: next state, bit-timing counters and shift datapath.
  always_comb begin
    w_state_nx = r_state;
    w_armed_nx = r_armed;
    w_cnt_nx   = r_cnt + CNT_W'(1);
    w_bit_nx   = r_bit;
    w_stop_nx  = r_stop;
    w_shift_nx = r_shift;
    w_par_nx   = r_par;
    w_ferr_nx  = r_ferr;
    w_zero_nx  = r_zero;
    w_done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nx   = '0;
        w_bit_nx   = '0;
        w_stop_nx  = 1'b0;
        w_ferr_nx  = 1'b0;
        w_zero_nx  = 1'b1;
        // Arming tracks rs, so a start needs a 1->0 edge seen while idle.
        w_armed_nx = w_rs;
        if (r_armed && !w_rs && en) begin
          w_state_nx = S_START;
          w_armed_nx = 1'b0;
        end
      end
      S_START: begin
        if (r_cnt == CNT_W'(HALF - 1)) begin
          w_cnt_nx = '0;
          if (w_rs) begin
            w_state_nx = S_IDLE;
            w_armed_nx = 1'b1;
          end else begin
            w_state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          w_cnt_nx   = '0;
          w_shift_nx = {w_rs, r_shift[DATA_W-1:1]};
          w_zero_nx  = r_zero & ~w_rs;
          w_bit_nx   = r_bit + BIT_W'(1);
          if (r_bit == BIT_W'(DATA_W - 1)) begin
            w_state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          w_cnt_nx   = '0;
          w_par_nx   = w_rs;
          w_zero_nx  = r_zero & ~w_rs;
          w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          w_cnt_nx  = '0;
          w_zero_nx = r_zero & ~w_rs;
          if (!w_rs) begin
            w_ferr_nx = 1'b1;
          end
          if (r_stop == 1'(STOP_BITS - 1)) begin
            // Return unarmed so a line stuck low cannot retrigger.
            w_done     = 1'b1;
            w_state_nx = S_IDLE;
            w_armed_nx = 1'b0;
          end else begin
            w_stop_nx = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_armed_nx = 1'b0;
      end
    endcase
  end

`ifdef UART_RX_BREAK_EN
  assign w_brk = w_zero_nx;
`else
  assign w_brk = 1'b0;
`endif

  // State register, synchroniser and frame datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_state <= S_IDLE;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_ferr  <= 1'b0;
      r_zero  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rxd};
      r_state <= w_state_nx;
      r_armed <= w_armed_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_stop  <= w_stop_nx;
      r_shift <= w_shift_nx;
      r_par   <= w_par_nx;
      r_ferr  <= w_ferr_nx;
      r_zero  <= w_zero_nx;
      busy    <= (w_state_nx != S_IDLE);
    end
  end

  // Holding register: a completion loads if empty or being drained this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_break_det  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_done) begin
        if (!r_valid || rx_if.rx_ready) begin
          r_data       <= w_shift_nx;
          r_valid      <= 1'b1;
          r_frame_err  <= w_ferr_nx;
          r_parity_err <= w_perr;
          r_break_det  <= w_brk;
        end else begin
          overrun <= 1'b1;
        end
      end else if (r_valid && rx_if.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data    = r_data;
  assign rx_if.rx_valid   = r_valid;
  assign rx_if.frame_err  = r_frame_err;
  assign rx_if.parity_err = r_parity_err;
  assign rx_if.break_det  = r_break_det;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: instance 0 is 8N1 at 12 clk/bit, instance 1 is
// 8 data, even parity, 2 stop bits at 8 clk/bit. A frame-level model predicts
// each word, its flags, its delivery cycle and the busy window.
module tb_uart_rx_param;

`ifdef UART_RX_BREAK_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  typedef struct {
    int         lo;
    int         hi;
    int         cyc;
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       bk;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] rxd;
  logic [1:0] rdy;

  logic [7:0] d_data [2];
  logic [1:0] d_valid, d_fe, d_pe, d_bk, d_ovr, d_busy;
  logic       ovr0, ovr1, busy0, busy1;

  uart_rx_param_if #(.DATA_W(8)) if0 ();
  uart_rx_param_if #(.DATA_W(8)) if1 ();

  uart_rx_param #(.CLKS_PER_BIT(12), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .en(en), .rxd(rxd[0]), .rx_if(if0),
    .overrun(ovr0), .busy(busy0)
  );

  uart_rx_param #(.CLKS_PER_BIT(8), .DATA_W(8), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .en(en), .rxd(rxd[1]), .rx_if(if1),
    .overrun(ovr1), .busy(busy1)
  );

  assign if0.rx_ready = rdy[0];
  assign if1.rx_ready = rdy[1];
  assign d_data[0] = if0.rx_data;
  assign d_data[1] = if1.rx_data;
  assign d_valid = {if1.rx_valid,   if0.rx_valid};
  assign d_fe    = {if1.frame_err,  if0.frame_err};
  assign d_pe    = {if1.parity_err, if0.parity_err};
  assign d_bk    = {if1.break_det,  if0.break_det};
  assign d_ovr   = {ovr1, ovr0};
  assign d_busy  = {busy1, busy0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cpb(input int i);
    return (i == 0) ? 12 : 8;
  endfunction
  function automatic int par(input int i);
    return (i == 0) ? 0 : 2;
  endfunction
  function automatic int sbits(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  // ---------------- frame-level model ----------------
  int         cyc = 0;
  int         rst_cyc = 0;
  exp_t       pend [2];
  logic [1:0] m_valid, m_fe, m_pe, m_bk, m_ovr;
  logic [7:0] m_data [2];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      m_ovr[i] <= 1'b0;
      if (rst) begin
        m_valid[i] <= 1'b0;
        m_data[i]  <= 8'h00;
        m_fe[i]    <= 1'b0;
        m_pe[i]    <= 1'b0;
        m_bk[i]    <= 1'b0;
      end else if (pend[i].cyc == cyc + 1 && pend[i].lo > rst_cyc) begin
        if (!m_valid[i] || rdy[i]) begin
          m_valid[i] <= 1'b1;
          m_data[i]  <= pend[i].d;
          m_fe[i]    <= pend[i].fe;
          m_pe[i]    <= pend[i].pe;
          m_bk[i]    <= pend[i].bk;
        end else begin
          m_ovr[i] <= 1'b1;
        end
      end else if (m_valid[i] && rdy[i]) begin
        m_valid[i] <= 1'b0;
      end
    end
  end

  // ---------------- stimulus and checking ----------------
  int         errors = 0;
  int         checks = 0;
  int         rises [2];
  int         rise_cyc [2];
  int         ovr_cnt [2];
  logic [7:0] w_data [2];
  logic [1:0] w_fe, w_pe, w_bk, pv;

  function automatic void chk(input string nm, input int i,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[%0d] cycle %0d: actual=%0h required=%0h", nm, i, cyc, act, req);
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk) #1;
  endtask

  task automatic drive_bit(input int i, input logic b);
    rxd[i] = b;
    repeat (cpb(i)) @(posedge clk) #1;
  endtask

  // Sends one frame. The synchroniser puts t0 two cycles after the rxd fall.
  task automatic send(input int i, input logic [7:0] d, input logic pbit,
                      input logic stopv, input bit detect, input int extra_low);
    int   n;
    int   t0;
    exp_t e;
    n = 8 + ((par(i) != 0) ? 1 : 0) + sbits(i);
    if (detect) begin
      t0    = cyc + 2;
      e.lo  = t0 + 1;
      e.hi  = t0 + cpb(i) / 2 + n * cpb(i);
      e.cyc = e.hi + 1;
      e.d   = d;
      e.fe  = !stopv;
      e.pe  = (par(i) != 0) && (((^d) ^ pbit) != (par(i) == 1));
      e.bk  = BRK_EN && (d == 8'h00) && (par(i) == 0 || !pbit) && !stopv;
      pend[i] = e;
    end
    drive_bit(i, 1'b0);
    for (int k = 0; k < 8; k++) drive_bit(i, d[k]);
    if (par(i) != 0) drive_bit(i, pbit);
    for (int k = 0; k < sbits(i); k++) drive_bit(i, stopv);
    repeat (extra_low) @(posedge clk) #1;
    rxd[i] = 1'b1;
  endtask

  initial begin
    int c0;
    int r0;
    rst = 1'b1;
    en  = 1'b1;
    rxd = 2'b11;
    rdy = 2'b11;
    for (int i = 0; i < 2; i++) begin
      pend[i].lo = 0; pend[i].hi = -1; pend[i].cyc = -1;
      pend[i].d = 8'h00; pend[i].fe = 1'b0; pend[i].pe = 1'b0; pend[i].bk = 1'b0;
      rises[i] = 0; rise_cyc[i] = 0; ovr_cnt[i] = 0; w_data[i] = 8'h00;
    end
    w_fe = '0; w_pe = '0; w_bk = '0; pv = '0;

    // Per-cycle compare against the model, plus word capture on rx_valid rise.
    fork
      forever begin
        @(negedge clk);
        if (cyc > 0) begin
          for (int i = 0; i < 2; i++) begin
            logic eb;
            eb = (cyc >= pend[i].lo) && (cyc <= pend[i].hi) &&
                 ((cyc < rst_cyc) || (pend[i].lo > rst_cyc));
            chk("rx_valid", i, 32'(d_valid[i]), 32'(m_valid[i]));
            chk("busy",     i, 32'(d_busy[i]),  32'(eb));
            chk("overrun",  i, 32'(d_ovr[i]),   32'(m_ovr[i]));
            if (m_valid[i]) begin
              chk("rx_data",    i, 32'(d_data[i]), 32'(m_data[i]));
              chk("frame_err",  i, 32'(d_fe[i]),   32'(m_fe[i]));
              chk("parity_err", i, 32'(d_pe[i]),   32'(m_pe[i]));
              chk("break_det",  i, 32'(d_bk[i]),   32'(m_bk[i]));
            end
            if (d_valid[i] === 1'b1 && pv[i] !== 1'b1) begin
              rises[i]++;
              rise_cyc[i] = cyc;
              w_data[i] = d_data[i];
              w_fe[i] = d_fe[i];
              w_pe[i] = d_pe[i];
              w_bk[i] = d_bk[i];
            end
            pv[i] = d_valid[i];
            if (d_ovr[i] === 1'b1) ovr_cnt[i]++;
          end
        end
      end
    join_none

    idle(3);
    rst = 1'b0;
    chk("reset_valid", 0, 32'(d_valid[0]), 32'd0);
    chk("reset_busy",  0, 32'(d_busy[0]),  32'd0);
    idle(4);

    // 8N1 0xA5: valid rises at t0+115, t0 = c0+2.
    c0 = cyc;
    send(0, 8'hA5, 1'b0, 1'b1, 1'b1, 0);
    idle(4);
    chk("a5_rise_cycle", 0, 32'(rise_cyc[0]), 32'(c0 + 117));
    chk("a5_data",       0, 32'(w_data[0]),   32'hA5);
    chk("a5_ferr",       0, 32'(w_fe[0]),     32'd0);
    chk("a5_perr",       0, 32'(w_pe[0]),     32'd0);

    // Even parity, 0x3C has even weight so parity bit 1 is wrong.
    send(1, 8'h3C, 1'b1, 1'b1, 1'b1, 0);
    idle(4);
    chk("3c_bad_perr", 1, 32'(w_pe[1]),   32'd1);
    chk("3c_bad_data", 1, 32'(w_data[1]), 32'h3C);
    send(1, 8'h3C, 1'b0, 1'b1, 1'b1, 0);
    idle(4);
    chk("3c_good_perr", 1, 32'(w_pe[1]), 32'd0);
    send(1, 8'h07, 1'b1, 1'b1, 1'b1, 0);
    idle(4);
    chk("07_perr", 1, 32'(w_pe[1]),   32'd0);
    chk("07_data", 1, 32'(w_data[1]), 32'h07);

    // Stop bit low, then a clean frame once the line has recovered.
    send(0, 8'h55, 1'b0, 1'b0, 1'b1, 0);
    idle(4);
    chk("55_ferr", 0, 32'(w_fe[0]),   32'd1);
    chk("55_data", 0, 32'(w_data[0]), 32'h55);
    send(0, 8'h12, 1'b0, 1'b1, 1'b1, 0);
    idle(4);
    chk("12_ferr", 0, 32'(w_fe[0]),   32'd0);
    chk("12_data", 0, 32'(w_data[0]), 32'h12);

    // Overrun: consumer stalled across two completions.
    rdy[0] = 1'b0;
    send(0, 8'h11, 1'b0, 1'b1, 1'b1, 0);
    idle(4);
    send(0, 8'h22, 1'b0, 1'b1, 1'b1, 0);
    idle(4);
    chk("ovr_pulses", 0, 32'(ovr_cnt[0]),  32'd1);
    chk("ovr_kept",   0, 32'(d_data[0]),   32'h11);
    chk("ovr_valid",  0, 32'(d_valid[0]),  32'd1);
    rdy[0] = 1'b1;
    idle(1);
    chk("ovr_drain", 0, 32'(d_valid[0]), 32'd0);
    idle(3);

    // Four-cycle low glitch: false start, busy window ends at t0+H.
    r0 = rises[0];
    pend[0].lo = cyc + 3;
    pend[0].hi = cyc + 2 + 6;
    pend[0].cyc = -1;
    rxd[0] = 1'b0;
    idle(4);
    rxd[0] = 1'b1;
    idle(12);
    chk("glitch_no_word", 0, 32'(rises[0]),  32'(r0));
    chk("glitch_busy",    0, 32'(d_busy[0]), 32'd0);

    // Reset in the middle of the data bits; 0xFF keeps the line high afterwards.
    r0 = rises[0];
    fork
      send(0, 8'hFF, 1'b0, 1'b1, 1'b1, 0);
      begin
        idle(50);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midrst_busy",  0, 32'(d_busy[0]),  32'd0);
        chk("midrst_valid", 0, 32'(d_valid[0]), 32'd0);
      end
    join
    idle(20);
    chk("midrst_no_word", 0, 32'(rises[0]), 32'(r0));

    // Enable low: frame ignored.
    r0 = rises[0];
    en = 1'b0;
    send(0, 8'h77, 1'b0, 1'b1, 1'b0, 0);
    idle(4);
    en = 1'b1;
    idle(4);
    chk("en_low_no_word", 0, 32'(rises[0]), 32'(r0));

    // Enable dropped mid-frame: frame still completes.
    fork
      send(0, 8'h5A, 1'b0, 1'b1, 1'b1, 0);
      begin
        idle(30);
        en = 1'b0;
      end
    join
    idle(4);
    en = 1'b1;
    chk("en_mid_data", 0, 32'(w_data[0]), 32'h5A);
    idle(4);

    // Line held low for two frame times: exactly one all-zero word.
    r0 = rises[0];
    send(0, 8'h00, 1'b0, 1'b0, 1'b1, 120);
    idle(30);
    chk("break_words", 0, 32'(rises[0]),  32'(r0 + 1));
    chk("break_data",  0, 32'(w_data[0]), 32'h00);
    chk("break_ferr",  0, 32'(w_fe[0]),   32'd1);
    chk("break_det",   0, 32'(w_bk[0]),   32'(BRK_EN));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, next generation of the fixed 8N1 divide-by-12 receiver. It provides configurable bit timing, data width, parity and stop bits, and mid-bit sampling with false-start rejection. Output is a valid/ready word interface with per-word error flags and overrun reporting. It sits between the rxd pad and the host-side register or FIFO logic.

Parameters:
CLKS_PER_BIT, 12, clk cycles per bit period (>=4, even); half-period H = CLKS_PER_BIT/2
DATA_W, 8, data bits per frame (5..9), LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  receiver enable; gates new frame starts only
rxd  in  1  serial input, asynchronous, idle high
rx_data  out  DATA_W  received word, held while rx_valid=1
rx_valid  out  1  word available
rx_ready  in  1  consumer accepts word when rx_valid & rx_ready
frame_err  out  1  stop-bit error for the presented word (qualified by rx_valid)
parity_err  out  1  parity error for the presented word (qualified by rx_valid)
overrun  out  1  one-cycle pulse: completed frame dropped because holding register full
busy  out  1  high in any state other than IDLE
break_det  out  1  break flag for the presented word (optional feature; 0 otherwise)

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE, counters=0, synchroniser FFs=1, rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, break_det=0. A reset mid-frame aborts the frame; no partial word is delivered.
- rxd passes through a 2-FF synchroniser; rs is the synchroniser output. All sampling uses rs.
- FSM states: IDLE, START, DATA, PARITY (skipped if PARITY=0), STOP, plus an ARM qualifier inside IDLE.
- IDLE: armed only after rs=1 has been seen. A 1->0 transition on rs while armed and en=1 goes to START. Call the cycle rs is first 0 "t0". bit_cnt and phase counter clear.
- START: sample rs at t0+H. If rs=1 (false start), return to IDLE with no flags. If rs=0, go to DATA.
- DATA: bit k (k=0..DATA_W-1) is sampled at t0+H+(k+1)*CLKS_PER_BIT and shifted in LSB first.
- PARITY: sample one bit period after the last data bit. parity_err = (XOR of data bits ^ parity bit) != (PARITY==1 ? 1 : 0).
- STOP: each stop bit is sampled at 1-bit spacing. Any stop sample of 0 sets frame_err for this word.
- Completion: the cycle after the final stop sample, the word and flags load into the holding register and rx_valid=1. The FSM returns to IDLE unarmed, so a line stuck low cannot retrigger.
- Latency, 8N1 with CLKS_PER_BIT=12: rx_valid rises at t0+115 (last sample at t0+114).
- Handshake: rx_valid stays high and rx_data/flags stay stable until rx_valid & rx_ready at posedge clk; rx_valid clears the next cycle.
- Completion and acceptance in the same cycle: the new word loads and rx_valid stays 1 (no bubble, no overrun).
- Completion while rx_valid=1 and rx_ready=0: the new word is discarded, the old word is kept, and overrun pulses for 1 cycle.
- en deassert mid-frame: the current frame completes normally; no new start is accepted while en=0.
- rx_data upper bits: none. Width is exactly DATA_W. With DATA_W=9 and PARITY=0, bit 8 is the 9th data bit.

Optional Feature:
Macro UART_RX_BREAK_EN.
- Defined: a frame whose data bits, parity bit (if any) and all stop samples are 0 is delivered with break_det=1 and frame_err=1, rx_data=0.
- Not defined: break_det is tied 0; the same frame is delivered as a frame_err=1 word with rx_data=0.

Test Plan:
- 8N1, CLKS_PER_BIT=12, send 0xA5, rx_ready=1 -> rx_valid single pulse at t0+115, rx_data=0xA5, no error flags.
- PARITY=2, send 0x3C with parity bit 1 (wrong) -> rx_data=0x3C, parity_err=1; repeat with parity 0 -> parity_err=0.
- 8N1, stop bit driven 0 on 0x55 -> frame_err=1, rx_data=0x55. The next frame is not detected until rxd returns high, then 0x12 is received clean.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses 1 cycle at 0x22 completion; assert rx_ready -> rx_valid drops.
- rxd low glitch of 4 cycles in IDLE -> no rx_valid, busy returns to 0 by t0+H+1. rst asserted mid-DATA -> all outputs at reset values the next cycle.
- rxd held low for 2 frames, with and without UART_RX_BREAK_EN -> break_det=1 or 0 respectively, frame_err=1, rx_data=0, and only one word delivered.
